// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - period, high-time and half-period scale meter for a slow square wave, in CCLK cycles
module clk_period_meter #(
    parameter int unsigned     W       = 32,
    parameter longint unsigned TIMEOUT = 1000000
) (
    input  logic         CCLK,
    input  logic         reset,
    input  logic         clk_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic [W-1:0] low_time,
    output logic [W-1:0] scale_est,
    output logic         valid,
    output logic         stalled
);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        MEASURE = 2'd1,
        STALL   = 2'd2
    } state_t;

    localparam logic [W-1:0] CNT_MAX   = '1;
    localparam logic [W-1:0] CNT_ONE   = W'(1);
    localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);

    state_t       state;
    logic         s1;
    logic         s2;
    logic         s3;
    logic [W-1:0] cnt;
    logic [W-1:0] hi_tmp;
    logic         seen_fall;

    logic rise;
    logic fall;
    logic timeout_hit;

    assign rise        = s2 & ~s3;
    assign fall        = ~s2 & s3;
    // A rise in the same cycle as the timeout match always wins.
    assign timeout_hit = (cnt == TIMEOUT_W) && !rise;

    always_ff @(posedge CCLK) begin
        if (reset) begin
            state     <= ACQUIRE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            cnt       <= '0;
            hi_tmp    <= '0;
            seen_fall <= 1'b0;
            period    <= '0;
            high_time <= '0;
            low_time  <= '0;
            scale_est <= '0;
            valid     <= 1'b0;
            stalled   <= 1'b0;
        end else begin
            s1    <= clk_in;
            s2    <= s1;
            s3    <= s2;
            valid <= 1'b0;

            if (rise) begin
                cnt <= CNT_ONE;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end

            if (fall) begin
                hi_tmp <= cnt;
            end

            if (rise) begin
                // A rise only closes a period if its falling edge was seen while measuring.
                if (state == MEASURE && seen_fall) begin
                    period    <= cnt;
                    high_time <= hi_tmp;
                    low_time  <= cnt - hi_tmp;
                    scale_est <= cnt >> 1;
                    valid     <= 1'b1;
                    stalled   <= 1'b0;
                end
                state     <= MEASURE;
                seen_fall <= 1'b0;
            end else if (timeout_hit && state != STALL) begin
                state     <= STALL;
                stalled   <= 1'b1;
                period    <= '0;
                high_time <= '0;
                low_time  <= '0;
                scale_est <= '0;
            end else if (fall && state == MEASURE) begin
                seen_fall <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - randomized scoreboard bench for clk_period_meter
module tb_clk_period_meter;

    localparam int W = 32;
    localparam int T = 50;

    logic         CCLK   = 1'b0;
    logic         reset  = 1'b1;
    logic         clk_in = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic [W-1:0] low_time;
    logic [W-1:0] scale_est;
    logic         valid;
    logic         stalled;

    clk_period_meter #(.W(W), .TIMEOUT(T)) dut (
        .CCLK      (CCLK),
        .reset     (reset),
        .clk_in    (clk_in),
        .period    (period),
        .high_time (high_time),
        .low_time  (low_time),
        .scale_est (scale_est),
        .valid     (valid),
        .stalled   (stalled)
    );

    always #5 CCLK = ~CCLK;

    typedef enum int {EV_CLEAR, EV_STALL, EV_VALID} ev_kind_t;
    typedef struct {
        int       at_edge;
        ev_kind_t kind;
        int       p;
        int       h;
        int       l;
        int       s;
    } ev_t;

    ev_t sb[$];
    int  edge_n = 0;
    int  total  = 0;
    int  bad    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    // Reference model: works on the sampled waveform as a list of edge indices.
    // A completed period is (this rise - previous rise) samples; results appear two edges later.
    initial begin
        bit have_ref;
        bit wd_on;
        bit prev;
        bit x;
        int anchor;
        int fall_idx;
        have_ref = 0;
        wd_on    = 1;
        prev     = 0;
        anchor   = 0;
        fall_idx = -1;
        forever begin
            @(posedge CCLK);
            edge_n++;
            if (reset) begin
                sb.delete();
                sb.push_back('{edge_n, EV_CLEAR, 0, 0, 0, 0});
                have_ref = 0;
                wd_on    = 1;
                prev     = 0;
                anchor   = edge_n - 1;
                fall_idx = -1;
            end else begin
                x = clk_in;
                if (x && !prev) begin
                    if (have_ref && fall_idx > anchor)
                        sb.push_back('{edge_n + 2, EV_VALID, edge_n - anchor, fall_idx - anchor,
                                       (edge_n - anchor) - (fall_idx - anchor), (edge_n - anchor) / 2});
                    have_ref = 1;
                    wd_on    = 1;
                    anchor   = edge_n;
                end else if (wd_on && (edge_n - anchor) == T) begin
                    sb.push_back('{edge_n + 2, EV_STALL, 0, 0, 0, 0});
                    wd_on    = 0;
                    have_ref = 0;
                end
                if (!x && prev) fall_idx = edge_n;
                prev = x;
            end
        end
    end

    // Monitor: after each edge, apply scheduled events and compare every output.
    initial begin
        bit  armed;
        bit  exp_valid;
        bit  exp_stalled;
        int  ep, eh, el, es;
        ev_t ev;
        armed = 0;
        exp_stalled = 0;
        ep = 0; eh = 0; el = 0; es = 0;
        forever begin
            @(negedge CCLK);
            exp_valid = 0;
            while (sb.size() > 0 && sb[0].at_edge <= edge_n) begin
                ev = sb.pop_front();
                if (ev.at_edge < edge_n) check("event_edge", 64'(ev.at_edge), 64'(edge_n));
                case (ev.kind)
                    EV_CLEAR: begin
                        armed = 1; exp_stalled = 0;
                        ep = 0; eh = 0; el = 0; es = 0;
                    end
                    EV_STALL: begin
                        exp_stalled = 1;
                        ep = 0; eh = 0; el = 0; es = 0;
                    end
                    default: begin
                        exp_valid = 1; exp_stalled = 0;
                        ep = ev.p; eh = ev.h; el = ev.l; es = ev.s;
                    end
                endcase
            end
            if (armed) begin
                check("valid", 64'(valid), 64'(exp_valid));
                check("stalled", 64'(stalled), 64'(exp_stalled));
                check("period", 64'(period), 64'(ep));
                check("high_time", 64'(high_time), 64'(eh));
                check("low_time", 64'(low_time), 64'(el));
                check("scale_est", 64'(scale_est), 64'(es));
            end
        end
    end

    task automatic hold(input bit lvl, input int n);
        repeat (n) begin
            @(negedge CCLK);
            clk_in = lvl;
        end
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        repeat (n) begin
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    task automatic pulse_reset();
        @(negedge CCLK);
        reset  = 1'b1;
        clk_in = 1'b0;
        @(negedge CCLK);
        reset  = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge CCLK);
        reset = 1'b0;
        hold(0, 4);
        wave(5, 5, 6);
        wave(3, 7, 5);
        wave(1, 1, 8);
        wave(20, 30, 3);
        wave(20, 31, 2);
        wave(5, 5, 2);
        hold(0, 80);
        wave(4, 4, 5);
        wave(5, 5, 3);
        hold(1, 5);
        hold(0, 2);
        pulse_reset();
        hold(0, 3);
        wave(5, 5, 3);
        wave(5, 5, 4);
        wave(12, 12, 5);
        pulse_reset();
        hold(0, 60);
        wave(2, 3, 3);
        repeat (150) begin
            int sel;
            sel = $urandom_range(0, 19);
            if (sel == 0) pulse_reset();
            else if (sel == 1) hold(0, $urandom_range(45, 70));
            else if (sel == 2) wave(1, 1, $urandom_range(1, 4));
            else wave($urandom_range(1, 20), $urandom_range(1, 20), 1);
        end
        hold(0, 10);
        check("queue_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
